// File: rtl/hyperbus_cfg_pkg.sv
// Shared types for the HyperBus boot-time configuration sequencer: table entry
// layout, sequencer states and default controller register offsets.
package hyperbus_cfg_pkg;

    localparam int unsigned CFG_ADDR_W = 32;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CFG_STRB_W = CFG_DATA_W / 8;

    // Fields are sized for the widest supported reg bus; the sequencer slices them.
    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
        logic [CFG_STRB_W-1:0] strb;
    } cfg_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } cfg_state_e;

    localparam logic [CFG_ADDR_W-1:0] REG_T_LATENCY_ACCESS = 32'h0000_0000;
    localparam logic [CFG_ADDR_W-1:0] REG_T_BURST_MAX      = 32'h0000_0004;
    localparam logic [CFG_ADDR_W-1:0] REG_ADDR_MAP_BASE    = 32'h0000_0020;

    function automatic cfg_entry_t cfg_entry(input logic [CFG_ADDR_W-1:0] addr,
                                             input logic [CFG_DATA_W-1:0] data,
                                             input logic [CFG_STRB_W-1:0] strb);
        cfg_entry_t e;
        e.addr = addr;
        e.data = data;
        e.strb = strb;
        return e;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_timer.sv
// Per-write timeout counter: counts while enabled, saturates at TimeoutCycles-1
// and flags expiry there.
module hyperbus_cfg_timer #(
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    output logic                expired_o
);

    logic [CntWidth-1:0] count_q;

    assign expired_o = (count_q == CntWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/hyperbus_cfg_seq.sv
// Boot-time configuration sequencer in front of the HyperBus reg-bus port:
// replays CfgTable as writes, then becomes a combinational host pass-through.
module hyperbus_cfg_seq
    import hyperbus_cfg_pkg::*;
#(
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter int unsigned NumEntries    = 4,
    parameter cfg_entry_t [NumEntries-1:0] CfgTable = '0,
    parameter int unsigned AutoStart     = 1,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [3:0]                err_idx_o,
    output logic [1:0]                dbg_state_o,
    input  logic [RegAddrWidth-1:0]   host_req_addr_i,
    input  logic                      host_req_write_i,
    input  logic [RegDataWidth-1:0]   host_req_wdata_i,
    input  logic [RegDataWidth/8-1:0] host_req_wstrb_i,
    input  logic                      host_req_valid_i,
    output logic [RegDataWidth-1:0]   host_rsp_rdata_o,
    output logic                      host_rsp_ready_o,
    output logic                      host_rsp_error_o,
    output logic [RegAddrWidth-1:0]   rbus_req_addr_o,
    output logic                      rbus_req_write_o,
    output logic [RegDataWidth-1:0]   rbus_req_wdata_o,
    output logic [RegDataWidth/8-1:0] rbus_req_wstrb_o,
    output logic                      rbus_req_valid_o,
    input  logic [RegDataWidth-1:0]   rbus_rsp_rdata_i,
    input  logic                      rbus_rsp_ready_i,
    input  logic                      rbus_rsp_error_i
);

    localparam int unsigned StrbWidth = RegDataWidth / 8;
    localparam logic [3:0]  LastIdx   = 4'(NumEntries - 1);

    cfg_state_e state_q, state_d;
    logic [3:0] index_q, index_d;
    logic [3:0] err_idx_q, err_idx_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       pend_q, pend_d;
    logic       first_q;
    logic       tmr_expired;
    cfg_entry_t cur_entry;

    // Registered index selects the entry; a loop keeps the index width lint-clean.
    always_comb begin
        cur_entry = '0;
        for (int i = 0; i < int'(NumEntries); i++) begin
            if (index_q == 4'(i)) cur_entry = CfgTable[i];
        end
    end

    hyperbus_cfg_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      ((state_q != ST_ISSUE) || rbus_rsp_ready_i),
        .en_i       (state_q == ST_ISSUE),
        .load_i     (1'b0),
        .load_val_i ('0),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            err_idx_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            pend_q    <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            err_idx_q <= err_idx_d;
            done_q    <= done_d;
            error_q   <= error_d;
            pend_q    <= pend_d;
            first_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        err_idx_d = err_idx_q;
        done_d    = done_q;
        error_d   = error_q;
        pend_d    = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (((AutoStart != 0) && first_q) || cfg_start_i) begin
                    state_d = ST_ISSUE;
                    index_d = '0;
                end
            end
            ST_ISSUE: begin
                if (rbus_rsp_ready_i) begin
                    if (rbus_rsp_error_i) begin
                        error_d   = 1'b1;
                        err_idx_d = index_q;
                        state_d   = ST_ERR;
                    end else if (index_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                    end
                end else if (tmr_expired) begin
                    error_d   = 1'b1;
                    err_idx_d = index_q;
                    state_d   = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (cfg_start_i) pend_d = 1'b1;
                // Restart only between host transfers so none is cut in half.
                if ((cfg_start_i || pend_q) && !host_req_valid_i) begin
                    pend_d  = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = '0;
                    state_d = ST_ISSUE;
                end
            end
        endcase
    end

    always_comb begin
        rbus_req_addr_o  = '0;
        rbus_req_write_o = 1'b0;
        rbus_req_wdata_o = '0;
        rbus_req_wstrb_o = '0;
        rbus_req_valid_o = 1'b0;
        host_rsp_rdata_o = '0;
        host_rsp_ready_o = 1'b0;
        host_rsp_error_o = 1'b0;
        unique case (state_q)
            ST_ISSUE: begin
                rbus_req_addr_o  = cur_entry.addr[RegAddrWidth-1:0];
                rbus_req_write_o = 1'b1;
                rbus_req_wdata_o = cur_entry.data[RegDataWidth-1:0];
                rbus_req_wstrb_o = cur_entry.strb[StrbWidth-1:0];
                rbus_req_valid_o = 1'b1;
            end
            ST_DONE, ST_ERR: begin
                rbus_req_addr_o  = host_req_addr_i;
                rbus_req_write_o = host_req_write_i;
                rbus_req_wdata_o = host_req_wdata_i;
                rbus_req_wstrb_o = host_req_wstrb_i;
                rbus_req_valid_o = host_req_valid_i;
                host_rsp_rdata_o = rbus_rsp_rdata_i;
                host_rsp_ready_o = rbus_rsp_ready_i;
                host_rsp_error_o = rbus_rsp_error_i;
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_q == ST_ISSUE);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_idx_o   = err_idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Bench for hyperbus_cfg_seq: randomized slave wait states, a write/read
// scoreboard and cycle-count expectations derived from the sequence rules.
`timescale 1ns/1ps
module tb_hyperbus_cfg_seq;
    import hyperbus_cfg_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam int W  = 69;  // {write, addr, data, strb}

    localparam cfg_entry_t [N-1:0] TABLE = {
        cfg_entry_t'{addr: 32'h0000_0020, data: 32'h8000_0000, strb: 4'h3},
        cfg_entry_t'{addr: 32'h0000_0004, data: 32'h0000_0100, strb: 4'hF},
        cfg_entry_t'{addr: 32'h0000_0000, data: 32'h0000_0006, strb: 4'hF}
    };

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_start_i = 1'b0;
    logic        busy_o, done_o, error_o;
    logic [3:0]  err_idx_o;
    logic [1:0]  dbg_state_o;
    logic [31:0] host_req_addr_i = '0;
    logic        host_req_write_i = 1'b0;
    logic [31:0] host_req_wdata_i = '0;
    logic [3:0]  host_req_wstrb_i = '0;
    logic        host_req_valid_i = 1'b0;
    logic [31:0] host_rsp_rdata_o;
    logic        host_rsp_ready_o, host_rsp_error_o;
    logic [31:0] rbus_req_addr_o;
    logic        rbus_req_write_o;
    logic [31:0] rbus_req_wdata_o;
    logic [3:0]  rbus_req_wstrb_o;
    logic        rbus_req_valid_o;
    logic [31:0] rbus_rsp_rdata_i = '0;
    logic        rbus_rsp_ready_i = 1'b0;
    logic        rbus_rsp_error_i = 1'b0;

    hyperbus_cfg_seq #(
        .RegAddrWidth  (32),
        .RegDataWidth  (32),
        .NumEntries    (N),
        .CfgTable      (TABLE),
        .AutoStart     (1),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .cfg_start_i      (cfg_start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .err_idx_o        (err_idx_o),
        .dbg_state_o      (dbg_state_o),
        .host_req_addr_i  (host_req_addr_i),
        .host_req_write_i (host_req_write_i),
        .host_req_wdata_i (host_req_wdata_i),
        .host_req_wstrb_i (host_req_wstrb_i),
        .host_req_valid_i (host_req_valid_i),
        .host_rsp_rdata_o (host_rsp_rdata_o),
        .host_rsp_ready_o (host_rsp_ready_o),
        .host_rsp_error_o (host_rsp_error_o),
        .rbus_req_addr_o  (rbus_req_addr_o),
        .rbus_req_write_o (rbus_req_write_o),
        .rbus_req_wdata_o (rbus_req_wdata_o),
        .rbus_req_wstrb_o (rbus_req_wstrb_o),
        .rbus_req_valid_o (rbus_req_valid_o),
        .rbus_rsp_rdata_i (rbus_rsp_rdata_i),
        .rbus_rsp_ready_i (rbus_rsp_ready_i),
        .rbus_rsp_error_i (rbus_rsp_error_i)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int wait_q[$];
    int err_at = -1;
    int wr_cnt = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_rdata(input logic [31:0] a);
        return (a == 32'h8) ? 32'h0000_00A5 : (32'h1234_5600 ^ a);
    endfunction

    // Slave model: per-transfer wait from wait_q (-1 = never ready), decided on negedge.
    initial begin : slave
        bit active = 0;
        int cur_wait = 0;
        int cnt = 0;
        forever begin
            @(negedge clk);
            rbus_rsp_ready_i = 1'b0;
            rbus_rsp_error_i = 1'b0;
            rbus_rsp_rdata_i = '0;
            if (!rbus_req_valid_o) begin
                active = 0;
            end else begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 1;
                end
                if (cur_wait >= 0 && cnt >= cur_wait) begin
                    rbus_rsp_ready_i = 1'b1;
                    active = 0;
                    if (rbus_req_write_o) begin
                        rbus_rsp_error_i = (wr_cnt == err_at);
                        wr_cnt++;
                    end else begin
                        rbus_rsp_rdata_i = slave_rdata(rbus_req_addr_o);
                    end
                    check("xfer_expected", W'(exp_q.size() > 0), W'(1));
                    if (exp_q.size() > 0)
                        check("xfer_content",
                              {rbus_req_write_o, rbus_req_addr_o, rbus_req_wdata_o, rbus_req_wstrb_o},
                              exp_q.pop_front());
                end else begin
                    cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start_i = 1'b1;
        @(posedge clk);
        #1;
        cfg_start_i = 1'b0;
    endtask

    task automatic push_cfg(input int upto);
        for (int i = 0; i < upto; i++)
            exp_q.push_back({1'b1, TABLE[i].addr, TABLE[i].data, TABLE[i].strb});
    endtask

    task automatic push_rand_waits(input int cnt, output int sum);
        sum = 0;
        for (int i = 0; i < cnt; i++) begin
            int w = $urandom_range(0, 4);
            wait_q.push_back(w);
            sum += w;
        end
    endtask

    // Called in cycle 0 (start condition present); sequence should finish at cycle N+sum_w+1.
    task automatic run_seq(input string tag, input int sum_w, input int host_at);
        int n = 0;
        int nv = 0;
        bit fin = 0;
        while (!fin && n < 200) begin
            step();
            n++;
            if (n == 1) check({tag, "_busy_rise"}, W'(busy_o), W'(1));
            if (busy_o) begin
                check({tag, "_host_stall"}, W'(host_rsp_ready_o), W'(0));
                if (rbus_req_valid_o) nv++;
            end
            if (n == host_at) host_req_valid_i = 1'b1;
            if (done_o || error_o) fin = 1;
        end
        check({tag, "_done_cycle"}, W'(n), W'(N + sum_w + 1));
        check({tag, "_valid_cycles"}, W'(nv), W'(N + sum_w));
        check({tag, "_done"}, W'(done_o), W'(1));
        check({tag, "_error"}, W'(error_o), W'(0));
        check({tag, "_busy_low"}, W'(busy_o), W'(0));
    endtask

    // Waits for the pass-through response to the current host request, then drops valid.
    task automatic wait_host_rsp(input string tag, input logic [31:0] exp_rdata, input bit chk_idle);
        int n = 0;
        while (!host_rsp_ready_o && n < 50) begin
            step();
            n++;
            if (chk_idle) check({tag, "_restart_held"}, W'(busy_o), W'(0));
        end
        check({tag, "_rsp_seen"}, W'(host_rsp_ready_o), W'(1));
        check({tag, "_rdata"}, W'(host_rsp_rdata_o), W'(exp_rdata));
        check({tag, "_rsp_err"}, W'(host_rsp_error_o), W'(0));
        @(posedge clk);
        #1;
        host_req_valid_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, W'(busy_o), W'(0));
        check({tag, "_done"}, W'(done_o), W'(0));
        check({tag, "_error"}, W'(error_o), W'(0));
        check({tag, "_err_idx"}, W'(err_idx_o), W'(0));
        check({tag, "_valid"}, W'(rbus_req_valid_o), W'(0));
        check({tag, "_host_ready"}, W'(host_rsp_ready_o), W'(0));
        check({tag, "_state"}, W'(dbg_state_o), W'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int sum;
        int n;
        int nv;
        logic [31:0] wd;

        rst_i = 1'b1;
        repeat (3) step();
        check_reset_vals("reset");

        // auto boot, two wait cycles per write
        for (int i = 0; i < N; i++) wait_q.push_back(2);
        push_cfg(N);
        rst_i = 1'b0;
        run_seq("auto_boot", 6, 0);

        // back-to-back with immediately ready slave
        for (int i = 0; i < N; i++) wait_q.push_back(0);
        push_cfg(N);
        pulse_start();
        run_seq("b2b", 0, 0);

        // randomized restarts
        for (int r = 0; r < 4; r++) begin
            push_rand_waits(N, sum);
            push_cfg(N);
            pulse_start();
            run_seq("rand_seq", sum, 0);
        end

        // error response on entry 1
        wr_cnt = 0;
        err_at = 1;
        push_rand_waits(2, sum);
        push_cfg(2);
        pulse_start();
        n = 0;
        while (!error_o && n < 100) begin
            step();
            n++;
        end
        check("err_flag", W'(error_o), W'(1));
        check("err_idx", W'(err_idx_o), W'(1));
        check("err_done", W'(done_o), W'(0));
        check("err_busy", W'(busy_o), W'(0));
        repeat (8) step();
        check("err_no_more", W'(exp_q.size()), W'(0));
        err_at = -1;
        wd = $urandom;
        host_req_addr_i  = 32'h0;
        host_req_write_i = 1'b0;
        host_req_wdata_i = wd;
        host_req_wstrb_i = 4'h0;
        exp_q.push_back({1'b0, 32'h0, wd, 4'h0});
        wait_q.push_back($urandom_range(0, 3));
        host_req_valid_i = 1'b1;
        wait_host_rsp("err_host_rd", slave_rdata(32'h0), 1'b0);

        // host read of 0x8 stalled during sequence, then forwarded; restart held by it
        push_rand_waits(N, sum);
        push_cfg(N);
        wd = $urandom;
        host_req_addr_i  = 32'h8;
        host_req_write_i = 1'b0;
        host_req_wdata_i = wd;
        host_req_wstrb_i = 4'h0;
        exp_q.push_back({1'b0, 32'h8, wd, 4'h0});
        wait_q.push_back(4);
        pulse_start();
        run_seq("stall", sum, 2);
        pulse_start();
        wait_host_rsp("stall_fwd", 32'h0000_00A5, 1'b1);
        step();
        check("restart_pending", W'(busy_o), W'(0));
        push_rand_waits(N, sum);
        push_cfg(N);
        run_seq("restart_after_host", sum, 0);

        // reset in the middle of ISSUE
        for (int i = 0; i < N; i++) wait_q.push_back(5);
        push_cfg(N);
        pulse_start();
        repeat (3) step();
        check("pre_rst_busy", W'(busy_o), W'(1));
        rst_i = 1'b1;
        step();
        check_reset_vals("mid_rst");
        exp_q.delete();
        wait_q.delete();
        step();
        push_rand_waits(N, sum);
        push_cfg(N);
        rst_i = 1'b0;
        run_seq("reboot", sum, 0);

        // timeout: slave never answers entry 0
        wait_q.push_back(-1);
        pulse_start();
        n = 0;
        nv = 0;
        while (n < 100) begin
            step();
            n++;
            if (rbus_req_valid_o) nv++;
            else if (nv > 0) break;
        end
        check("to_valid_cycles", W'(nv), W'(TO));
        check("to_error", W'(error_o), W'(1));
        check("to_err_idx", W'(err_idx_o), W'(0));
        check("to_done", W'(done_o), W'(0));
        check("to_busy", W'(busy_o), W'(0));
        check("to_sb_empty", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
